ucpu_bus_sequencer: RTL and testbench
=====================================

// Module: ucpu_bus_sequencer
// PURPOSE
//  Parametrised successor to the micro-decode shared write bus: N-source bus mux with registered
//  output and one-hot consumer write strobes, plus the micro-PC sequencer (conditional branch, jump,
//  call/return stack, halt/fault).
//  Sits between the micro-ROM (supplies the micro-instruction at m_pc) and the datapath registers.
// PARAMETERS
//  DATA_W        8  bus / source / immediate width
//  NSRC          8  number of bus producers; SRC_W = $clog2(NSRC)
//  NDST          8  number of bus consumers; DST_W = $clog2(NDST)
//  MPC_W         8  micro-PC and branch-target width
//  RSTACK_DEPTH  4  return-stack entries (>=1)
// PORTS
//  sys_clk        in   1             single clock, all state on posedge
//  sys_rst        in   1             synchronous, active-high reset
//  src_data       in   NSRC*DATA_W   flattened producers; source i = [i*DATA_W +: DATA_W]
//  minstr_valid   in   1             micro-instruction at m_pc is valid
//  minstr_type    in   3             0 NOP,1 MOVE,2 MOVI,3 BR,4 JUMP,5 CALL,6 RET,7 HALT
//  src_sel        in   SRC_W         MOVE source / BR compare source
//  dst_sel        in   DST_W         MOVE/MOVI consumer index
//  imm            in   DATA_W        MOVI data / BR compare value
//  mbranch_target in   MPC_W         BR/JUMP/CALL target
//  stall_in       in   1             consumer busy; freezes sequencer
//  m_pc           out  MPC_W         micro-PC (address of instruction being presented)
//  bus_q          out  DATA_W        registered bus value
//  dst_we         out  NDST          one-hot write strobe, valid with bus_q
//  halted         out  1             state HALT
//  fault          out  1             state FAULT
// BEHAVIOUR
//  Reset: m_pc=0, bus_q=0, dst_we=0, stack pointer=0 (empty), state RUN, halted=0, fault=0.
//  States: RUN, HALT, FAULT. HALT/FAULT exit only via sys_rst; in both, m_pc/bus_q hold, dst_we=0.
//  Issue: instruction consumed on posedge iff state==RUN && minstr_valid && !stall_in.
//  Not consumed: m_pc holds, dst_we=0 next cycle, bus_q holds.
//  Latency 1: consumed MOVE/MOVI -> next cycle bus_q = data, dst_we = one-hot(dst_sel); pulse 1 cycle.
//  dst_sel >= NDST: dst_we stays 0 (bus_q still updates). src_sel >= NSRC: source value = 0.
//  Next m_pc (mod 2^MPC_W; m_pc=2^MPC_W-1 +1 wraps to 0):
//   NOP/MOVE/MOVI: m_pc+1
//   BR: src[src_sel]==imm ? mbranch_target : m_pc+1
//   JUMP: mbranch_target
//   CALL: push m_pc+1 (wrapped), m_pc=mbranch_target
//   RET: pop -> m_pc
//   HALT: m_pc holds, state->HALT.
//  Stack: CALL when full (RSTACK_DEPTH entries) -> no push, m_pc holds, state->FAULT.
//  Stack: RET when empty -> m_pc holds, state->FAULT.
//  Non-MOVE types leave bus_q unchanged and dst_we=0.
//  stall_in has priority over minstr_valid; a pending dst_we pulse already issued still completes.
//  Reset asserted mid-operation overrides everything in that cycle (incl. an issuing CALL).
// CONFIGURATION
//  UCPU_BUS_BRGT_EN defined: extra input cmp_gt_mode (1 bit).
//   BR with cmp_gt_mode=1 takes branch iff src[src_sel] > imm (unsigned); cmp_gt_mode=0 -> equality.
//  Undefined: port absent, BR is equality only; all else identical.
// TESTING
//  1 Reset, MOVI dst=2 imm=0x5A at m_pc=0 -> next cycle bus_q=0x5A, dst_we=0x04, m_pc=1.
//  2 MOVE src=3 (src3=0x11) then BR src=3 imm=0x11 tgt=0x40 -> m_pc=0x40.
//    Repeat with imm=0x12 -> m_pc+1.
//  3 m_pc=0xFF NOP -> m_pc=0x00.
//    CALL tgt=0x10 at 0xFF -> pushes 0x00; RET -> m_pc=0x00.
//  4 RSTACK_DEPTH=4: 4 CALLs ok; 5th CALL -> fault=1, m_pc held, dst_we=0 thereafter.
//    Separately RET at reset -> fault=1.
//  5 stall_in=1 for 3 cycles with MOVE valid -> m_pc, bus_q frozen, dst_we=0.
//    Release -> MOVE issues once.
//    HALT -> halted=1 until sys_rst.
//  6 UCPU_BUS_BRGT_EN: src=0x80, imm=0x7F, cmp_gt_mode=1 -> branch taken; imm=0x80 -> not taken.

Source files
------------

// File: rtl/ucpu_bus_sequencer.sv
// Micro-sequencer with registered N-source write bus and one-hot consumer strobes.
// Optional macro UCPU_BUS_BRGT_EN adds cmp_gt_mode for unsigned greater-than branches.
module ucpu_bus_sequencer #(
  parameter int unsigned DATA_W       = 8,
  parameter int unsigned NSRC         = 8,
  parameter int unsigned NDST         = 8,
  parameter int unsigned MPC_W        = 8,
  parameter int unsigned RSTACK_DEPTH = 4,
  localparam int unsigned SRC_W       = (NSRC > 1) ? $clog2(NSRC) : 1,
  localparam int unsigned DST_W       = (NDST > 1) ? $clog2(NDST) : 1
) (
  input  logic                   sys_clk,
  input  logic                   sys_rst,
  input  logic [NSRC*DATA_W-1:0] src_data,
  input  logic                   minstr_valid,
  input  logic [2:0]             minstr_type,
  input  logic [SRC_W-1:0]       src_sel,
  input  logic [DST_W-1:0]       dst_sel,
  input  logic [DATA_W-1:0]      imm,
  input  logic [MPC_W-1:0]       mbranch_target,
  input  logic                   stall_in,
`ifdef UCPU_BUS_BRGT_EN
  input  logic                   cmp_gt_mode,
`endif
  output logic [MPC_W-1:0]       m_pc,
  output logic [DATA_W-1:0]      bus_q,
  output logic [NDST-1:0]        dst_we,
  output logic                   halted,
  output logic                   fault
);

  localparam int unsigned SP_W      = $clog2(RSTACK_DEPTH + 1);
  localparam int unsigned STK_IDX_W = (RSTACK_DEPTH > 1) ? $clog2(RSTACK_DEPTH) : 1;

  localparam logic [2:0] OpNop  = 3'd0;
  localparam logic [2:0] OpMove = 3'd1;
  localparam logic [2:0] OpMovi = 3'd2;
  localparam logic [2:0] OpBr   = 3'd3;
  localparam logic [2:0] OpJump = 3'd4;
  localparam logic [2:0] OpCall = 3'd5;
  localparam logic [2:0] OpRet  = 3'd6;
  localparam logic [2:0] OpHalt = 3'd7;

  typedef enum logic [1:0] {StRun, StHalt, StFault} state_e;

  state_e             r_state;
  logic [MPC_W-1:0]   r_pc;
  logic [DATA_W-1:0]  r_bus;
  logic [NDST-1:0]    r_dst_we;
  logic [SP_W-1:0]    r_sp;
  logic [MPC_W-1:0]   r_stack [RSTACK_DEPTH];

  logic               w_issue;
  logic [DATA_W-1:0]  w_src_val;
  logic [NDST-1:0]    w_dst_oh;
  logic               w_br_take;
  logic [MPC_W-1:0]   w_pc_inc;
  logic               w_stk_full;
  logic               w_stk_empty;
  logic [STK_IDX_W-1:0] w_push_idx;
  logic [STK_IDX_W-1:0] w_pop_idx;

  assign w_issue     = (r_state == StRun) && minstr_valid && !stall_in;
  assign w_pc_inc    = r_pc + MPC_W'(1);
  assign w_stk_full  = (r_sp == SP_W'(RSTACK_DEPTH));
  assign w_stk_empty = (r_sp == '0);
  assign w_push_idx  = STK_IDX_W'(r_sp);
  assign w_pop_idx   = STK_IDX_W'(r_sp - SP_W'(1));

  // Out-of-range selects fall through the loops: source reads 0, no strobe fires.
  always_comb begin
    w_src_val = '0;
    for (int unsigned i = 0; i < NSRC; i++) begin
      if (32'(src_sel) == i) w_src_val = src_data[i*DATA_W +: DATA_W];
    end
  end

  always_comb begin
    w_dst_oh = '0;
    for (int unsigned i = 0; i < NDST; i++) begin
      if (32'(dst_sel) == i) w_dst_oh[i] = 1'b1;
    end
  end

`ifdef UCPU_BUS_BRGT_EN
  assign w_br_take = cmp_gt_mode ? (w_src_val > imm) : (w_src_val == imm);
`else
  assign w_br_take = (w_src_val == imm);
`endif

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_state  <= StRun;
      r_pc     <= '0;
      r_bus    <= '0;
      r_dst_we <= '0;
      r_sp     <= '0;
    end else begin
      r_dst_we <= '0;
      if (w_issue) begin
        case (minstr_type)
          OpNop: r_pc <= w_pc_inc;
          OpMove: begin
            r_bus    <= w_src_val;
            r_dst_we <= w_dst_oh;
            r_pc     <= w_pc_inc;
          end
          OpMovi: begin
            r_bus    <= imm;
            r_dst_we <= w_dst_oh;
            r_pc     <= w_pc_inc;
          end
          OpBr:   r_pc <= w_br_take ? mbranch_target : w_pc_inc;
          OpJump: r_pc <= mbranch_target;
          OpCall: begin
            if (w_stk_full) begin
              r_state <= StFault;
            end else begin
              r_stack[w_push_idx] <= w_pc_inc;
              r_sp                <= r_sp + SP_W'(1);
              r_pc                <= mbranch_target;
            end
          end
          OpRet: begin
            if (w_stk_empty) begin
              r_state <= StFault;
            end else begin
              r_pc <= r_stack[w_pop_idx];
              r_sp <= r_sp - SP_W'(1);
            end
          end
          OpHalt: r_state <= StHalt;
          default: ;
        endcase
      end
    end
  end

  assign m_pc   = r_pc;
  assign bus_q  = r_bus;
  assign dst_we = r_dst_we;
  assign halted = (r_state == StHalt);
  assign fault  = (r_state == StFault);

endmodule

// File: tb/tb_ucpu_bus_sequencer.sv
// Self-checking bench for ucpu_bus_sequencer: directed scenarios plus randomized
// instruction stream compared against a queue-based architectural model.
module tb_ucpu_bus_sequencer;

  logic        sys_clk = 1'b0;
  logic        sys_rst;
  logic [63:0] src_data;
  logic        minstr_valid;
  logic [2:0]  minstr_type;
  logic [2:0]  src_sel;
  logic [2:0]  dst_sel;
  logic [7:0]  imm;
  logic [7:0]  mbranch_target;
  logic        stall_in;
  logic        cmp_gt_mode;
  logic [7:0]  m_pc;
  logic [7:0]  bus_q;
  logic [7:0]  dst_we;
  logic        halted;
  logic        fault;

  int checks = 0;
  int errors = 0;

  // Architectural model state
  int e_pc, e_bus, e_we;
  bit e_halt, e_fault;
  int stk[$];

  ucpu_bus_sequencer dut (
    .sys_clk        (sys_clk),
    .sys_rst        (sys_rst),
    .src_data       (src_data),
    .minstr_valid   (minstr_valid),
    .minstr_type    (minstr_type),
    .src_sel        (src_sel),
    .dst_sel        (dst_sel),
    .imm            (imm),
    .mbranch_target (mbranch_target),
    .stall_in       (stall_in),
`ifdef UCPU_BUS_BRGT_EN
    .cmp_gt_mode    (cmp_gt_mode),
`endif
    .m_pc           (m_pc),
    .bus_q          (bus_q),
    .dst_we         (dst_we),
    .halted         (halted),
    .fault          (fault)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic model_step();
    int sval;
    bit take;
    if (sys_rst) begin
      e_pc = 0; e_bus = 0; e_we = 0; e_halt = 0; e_fault = 0;
      stk.delete();
      return;
    end
    e_we = 0;
    if (e_halt || e_fault || !minstr_valid || stall_in) return;
    sval = int'(src_data[int'(src_sel)*8 +: 8]);
    case (int'(minstr_type))
      0: e_pc = (e_pc + 1) % 256;
      1: begin e_bus = sval; e_we = 1 << int'(dst_sel); e_pc = (e_pc + 1) % 256; end
      2: begin e_bus = int'(imm); e_we = 1 << int'(dst_sel); e_pc = (e_pc + 1) % 256; end
      3: begin
        take = (sval == int'(imm));
`ifdef UCPU_BUS_BRGT_EN
        if (cmp_gt_mode) take = (sval > int'(imm));
`endif
        e_pc = take ? int'(mbranch_target) : (e_pc + 1) % 256;
      end
      4: e_pc = int'(mbranch_target);
      5: begin
        if (stk.size() == 4) e_fault = 1;
        else begin stk.push_back((e_pc + 1) % 256); e_pc = int'(mbranch_target); end
      end
      6: begin
        if (stk.size() == 0) e_fault = 1;
        else e_pc = stk.pop_back();
      end
      default: e_halt = 1;
    endcase
  endtask

  task automatic set_in(input bit v, input bit st, input int ty, input int s, input int d,
                        input int im, input int tg);
    minstr_valid   = v;
    stall_in       = st;
    minstr_type    = 3'(ty);
    src_sel        = 3'(s);
    dst_sel        = 3'(d);
    imm            = 8'(im);
    mbranch_target = 8'(tg);
  endtask

  task automatic tick();
    model_step();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic do_reset();
    sys_rst = 1'b1;
    set_in(0, 0, 0, 0, 0, 0, 0);
    tick();
    sys_rst = 1'b0;
  endtask

  task automatic test_reset();
    sys_rst = 1'b0;
    set_in(1, 0, 2, 0, 3, 8'hAA, 0);
    tick();
    do_reset();
    checks++;
    if ({m_pc, bus_q, dst_we, halted, fault} !== {8'h00, 8'h00, 8'h00, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset: got pc=%h bus=%h we=%h h=%b f=%b want all zero",
               m_pc, bus_q, dst_we, halted, fault);
    end
  endtask

  task automatic test_movi();
    do_reset();
    set_in(1, 0, 2, 0, 2, 8'h5A, 0);
    tick();
    checks++;
    if ({m_pc, bus_q, dst_we} !== {8'h01, 8'h5A, 8'h04}) begin
      errors++;
      $display("FAIL movi: got pc=%h bus=%h we=%h want pc=01 bus=5a we=04", m_pc, bus_q, dst_we);
    end
    set_in(0, 0, 2, 0, 2, 8'h00, 0);
    tick();
    checks++;
    if ({m_pc, bus_q, dst_we} !== {8'h01, 8'h5A, 8'h00}) begin
      errors++;
      $display("FAIL movi_pulse: got pc=%h bus=%h we=%h want pc=01 bus=5a we=00",
               m_pc, bus_q, dst_we);
    end
  endtask

  task automatic test_move_branch();
    do_reset();
    src_data = 64'h0;
    src_data[3*8 +: 8] = 8'h11;
    set_in(1, 0, 1, 3, 5, 0, 0);
    tick();
    checks++;
    if ({m_pc, bus_q, dst_we} !== {8'h01, 8'h11, 8'h20}) begin
      errors++;
      $display("FAIL move: got pc=%h bus=%h we=%h want pc=01 bus=11 we=20", m_pc, bus_q, dst_we);
    end
    set_in(1, 0, 3, 3, 0, 8'h11, 8'h40);
    tick();
    checks++;
    if ({m_pc, bus_q, dst_we} !== {8'h40, 8'h11, 8'h00}) begin
      errors++;
      $display("FAIL br_taken: got pc=%h bus=%h we=%h want pc=40 bus=11 we=00",
               m_pc, bus_q, dst_we);
    end
    set_in(1, 0, 3, 3, 0, 8'h12, 8'h80);
    tick();
    checks++;
    if (m_pc !== 8'h41) begin
      errors++;
      $display("FAIL br_not_taken: got pc=%h want 41", m_pc);
    end
  endtask

  task automatic test_wrap_call();
    do_reset();
    set_in(1, 0, 4, 0, 0, 0, 8'hFF);
    tick();
    set_in(1, 0, 0, 0, 0, 0, 0);
    tick();
    checks++;
    if (m_pc !== 8'h00) begin
      errors++;
      $display("FAIL pc_wrap: got pc=%h want 00", m_pc);
    end
    set_in(1, 0, 4, 0, 0, 0, 8'hFF);
    tick();
    set_in(1, 0, 5, 0, 0, 0, 8'h10);
    tick();
    checks++;
    if ({m_pc, fault} !== {8'h10, 1'b0}) begin
      errors++;
      $display("FAIL call_wrap: got pc=%h f=%b want pc=10 f=0", m_pc, fault);
    end
    set_in(1, 0, 6, 0, 0, 0, 0);
    tick();
    checks++;
    if ({m_pc, fault} !== {8'h00, 1'b0}) begin
      errors++;
      $display("FAIL ret_wrap: got pc=%h f=%b want pc=00 f=0", m_pc, fault);
    end
  endtask

  task automatic test_stack_fault();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      set_in(1, 0, 5, 0, 0, 0, 8'h20 + i);
      tick();
    end
    checks++;
    if ({m_pc, fault} !== {8'h23, 1'b0}) begin
      errors++;
      $display("FAIL call4: got pc=%h f=%b want pc=23 f=0", m_pc, fault);
    end
    set_in(1, 0, 5, 0, 0, 0, 8'h30);
    tick();
    checks++;
    if ({m_pc, dst_we, fault} !== {8'h23, 8'h00, 1'b1}) begin
      errors++;
      $display("FAIL call_overflow: got pc=%h we=%h f=%b want pc=23 we=00 f=1",
               m_pc, dst_we, fault);
    end
    set_in(1, 0, 2, 0, 1, 8'h77, 0);
    tick();
    checks++;
    if ({m_pc, bus_q, dst_we, fault} !== {8'h23, 8'h00, 8'h00, 1'b1}) begin
      errors++;
      $display("FAIL fault_hold: got pc=%h bus=%h we=%h f=%b want pc=23 bus=00 we=00 f=1",
               m_pc, bus_q, dst_we, fault);
    end
    do_reset();
    set_in(1, 0, 6, 0, 0, 0, 0);
    tick();
    checks++;
    if ({m_pc, fault} !== {8'h00, 1'b1}) begin
      errors++;
      $display("FAIL ret_empty: got pc=%h f=%b want pc=00 f=1", m_pc, fault);
    end
  endtask

  task automatic test_stall_halt();
    do_reset();
    src_data = 64'h0;
    src_data[2*8 +: 8] = 8'h3C;
    for (int i = 0; i < 3; i++) begin
      set_in(1, 1, 1, 2, 6, 0, 0);
      tick();
      checks++;
      if ({m_pc, bus_q, dst_we} !== {8'h00, 8'h00, 8'h00}) begin
        errors++;
        $display("FAIL stall_%0d: got pc=%h bus=%h we=%h want 00 00 00", i, m_pc, bus_q, dst_we);
      end
    end
    set_in(1, 0, 1, 2, 6, 0, 0);
    tick();
    checks++;
    if ({m_pc, bus_q, dst_we} !== {8'h01, 8'h3C, 8'h40}) begin
      errors++;
      $display("FAIL stall_release: got pc=%h bus=%h we=%h want pc=01 bus=3c we=40",
               m_pc, bus_q, dst_we);
    end
    set_in(0, 0, 1, 2, 6, 0, 0);
    tick();
    checks++;
    if ({m_pc, dst_we} !== {8'h01, 8'h00}) begin
      errors++;
      $display("FAIL issue_once: got pc=%h we=%h want pc=01 we=00", m_pc, dst_we);
    end
    set_in(1, 0, 7, 0, 0, 0, 0);
    tick();
    for (int i = 0; i < 3; i++) begin
      set_in(1, 0, 4, 0, 0, 0, 8'h99);
      tick();
    end
    checks++;
    if ({m_pc, halted, fault} !== {8'h01, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL halt_hold: got pc=%h h=%b f=%b want pc=01 h=1 f=0", m_pc, halted, fault);
    end
    do_reset();
    checks++;
    if ({m_pc, halted} !== {8'h00, 1'b0}) begin
      errors++;
      $display("FAIL halt_reset: got pc=%h h=%b want pc=00 h=0", m_pc, halted);
    end
  endtask

  task automatic test_reset_mid_call();
    do_reset();
    set_in(1, 0, 4, 0, 0, 0, 8'h50);
    tick();
    sys_rst = 1'b1;
    set_in(1, 0, 5, 0, 0, 0, 8'h60);
    tick();
    sys_rst = 1'b0;
    checks++;
    if ({m_pc, fault} !== {8'h00, 1'b0}) begin
      errors++;
      $display("FAIL reset_call: got pc=%h f=%b want pc=00 f=0", m_pc, fault);
    end
    set_in(1, 0, 6, 0, 0, 0, 0);
    tick();
    checks++;
    if (fault !== 1'b1) begin
      errors++;
      $display("FAIL reset_call_nopush: got f=%b want 1", fault);
    end
  endtask

`ifdef UCPU_BUS_BRGT_EN
  task automatic test_brgt();
    do_reset();
    src_data = 64'h0;
    src_data[4*8 +: 8] = 8'h80;
    cmp_gt_mode = 1'b1;
    set_in(1, 0, 3, 4, 0, 8'h7F, 8'h33);
    tick();
    checks++;
    if (m_pc !== 8'h33) begin
      errors++;
      $display("FAIL brgt_taken: got pc=%h want 33", m_pc);
    end
    set_in(1, 0, 3, 4, 0, 8'h80, 8'h44);
    tick();
    checks++;
    if (m_pc !== 8'h34) begin
      errors++;
      $display("FAIL brgt_not_taken: got pc=%h want 34", m_pc);
    end
    cmp_gt_mode = 1'b0;
    set_in(1, 0, 3, 4, 0, 8'h80, 8'h55);
    tick();
    checks++;
    if (m_pc !== 8'h55) begin
      errors++;
      $display("FAIL brgt_eq_mode: got pc=%h want 55", m_pc);
    end
  endtask
`endif

  task automatic test_random();
    int ty;
    do_reset();
    for (int n = 0; n < 800; n++) begin
      sys_rst  = ($urandom_range(0, 59) == 0);
      src_data = {$urandom, $urandom};
      ty = $urandom_range(0, 7);
      if (ty == 7 && $urandom_range(0, 3) != 0) ty = 1;
      set_in(($urandom_range(0, 7) != 0), ($urandom_range(0, 4) == 0), ty,
             $urandom_range(0, 7), $urandom_range(0, 7),
             (($urandom_range(0, 3) == 0) ? int'(src_data[7:0]) : $urandom_range(0, 255)),
             $urandom_range(0, 255));
      if ($urandom_range(0, 2) == 0) src_sel = 3'd0;
      cmp_gt_mode = 1'($urandom_range(0, 1));
      tick();
      checks++;
      if ({m_pc, bus_q, dst_we, halted, fault} !==
          {8'(e_pc), 8'(e_bus), 8'(e_we), e_halt, e_fault}) begin
        errors++;
        $display("FAIL random_%0d: got pc=%h bus=%h we=%h h=%b f=%b want pc=%h bus=%h we=%h h=%b f=%b",
                 n, m_pc, bus_q, dst_we, halted, fault,
                 8'(e_pc), 8'(e_bus), 8'(e_we), e_halt, e_fault);
      end
    end
    sys_rst = 1'b0;
  endtask

  initial begin
    sys_rst     = 1'b1;
    src_data    = 64'h0;
    cmp_gt_mode = 1'b0;
    set_in(0, 0, 0, 0, 0, 0, 0);
    test_reset();
    test_movi();
    test_move_branch();
    test_wrap_call();
    test_stack_fault();
    test_stall_halt();
    test_reset_mid_call();
`ifdef UCPU_BUS_BRGT_EN
    test_brgt();
`endif
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
